// File: rtl/doraemon_tx.sv
// doraemon_tx: transmitter feeding candidate records into the clk1 side of
// the doraemon selection block. Upstream records are staged in a small
// circular buffer. Each session sends a fixed burst of initial beats
// regardless of the receiver, then streams only while the receiver is
// ready, and stops after TOTAL beats.
module doraemon_tx #(
  parameter int ID_W  = 5,
  parameter int D_W   = 8,
  parameter int W_W   = 3,
  parameter int DEPTH = 4,
  parameter int TOTAL = 6000
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [ID_W-1:0]   src_id,
  input  logic [D_W-1:0]    src_size,
  input  logic [D_W-1:0]    src_iq,
  input  logic [D_W-1:0]    src_eq,
  input  logic [W_W-1:0]    src_size_w,
  input  logic [W_W-1:0]    src_iq_w,
  input  logic [W_W-1:0]    src_eq_w,
  input  logic              ready,
  output logic              in_valid,
  output logic [ID_W-1:0]   doraemon_id,
  output logic [D_W-1:0]    size,
  output logic [D_W-1:0]    iq_score,
  output logic [D_W-1:0]    eq_score,
  output logic [W_W-1:0]    size_weight,
  output logic [W_W-1:0]    iq_weight,
  output logic [W_W-1:0]    eq_weight,
  output logic [12:0]       sent_cnt,
  output logic              done
);

  localparam int REC_W = ID_W + 3 * D_W + 3 * W_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [12:0] TOTAL_C = 13'(TOTAL);
  localparam logic [12:0] INIT_C  = 13'd5;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    STREAM,
    DONE
  } state_t;

  state_t           state_q;
  logic [REC_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [REC_W-1:0] outRec_q;
  logic             inValid_q;
  logic [12:0]      sentCnt_q, sentCnt_d;
  logic             done_q;

  logic             push;
  logic             pop;
  logic             empty;
  logic [REC_W-1:0] srcRec;
  logic [REC_W-1:0] headRec;

  assign srcRec    = {src_id, src_size, src_iq, src_eq, src_size_w, src_iq_w, src_eq_w};
  assign headRec   = mem_q[rdPtr_q];
  assign empty     = (count_q == '0);
  assign src_ready = (count_q < CNT_W'(DEPTH));
  assign push      = src_valid && src_ready;

  // Decide whether a beat leaves the buffer on this edge: the initial burst
  // ignores the receiver, streaming waits for its ready.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      INIT:    pop = !empty;
      STREAM:  pop = ready && !empty;
      default: pop = 1'b0;
    endcase
  end

  // Next pointer, occupancy and saturating beat count values.
  always_comb begin
    wrPtr_d   = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d   = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    count_d   = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    sentCnt_d = (sentCnt_q >= TOTAL_C) ? sentCnt_q : sentCnt_q + 13'd1;
  end

  // Record storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk1) begin
    if (push) begin
      mem_q[wrPtr_q] <= srcRec;
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Session FSM with registered beat outputs, beat counter and done flag.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      inValid_q <= 1'b0;
      outRec_q  <= '0;
      sentCnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      inValid_q <= pop;
      outRec_q  <= pop ? headRec : '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= INIT;
            sentCnt_q <= '0;
          end
        end
        INIT: begin
          if (pop) begin
            sentCnt_q <= sentCnt_d;
            if (sentCnt_d >= TOTAL_C) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (sentCnt_d == INIT_C) begin
              state_q <= STREAM;
            end
          end
        end
        STREAM: begin
          if (pop) begin
            sentCnt_q <= sentCnt_d;
            if (sentCnt_d >= TOTAL_C) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state_q   <= INIT;
            sentCnt_q <= '0;
            done_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_valid    = inValid_q;
  assign doraemon_id = outRec_q[REC_W-1 -: ID_W];
  assign size        = outRec_q[3*W_W+3*D_W-1 -: D_W];
  assign iq_score    = outRec_q[3*W_W+2*D_W-1 -: D_W];
  assign eq_score    = outRec_q[3*W_W+D_W-1 -: D_W];
  assign size_weight = outRec_q[3*W_W-1 -: W_W];
  assign iq_weight   = outRec_q[2*W_W-1 -: W_W];
  assign eq_weight   = outRec_q[W_W-1:0];
  assign sent_cnt    = sentCnt_q;
  assign done        = done_q;

endmodule
